genie_split: RTL and testbench
==============================

GENIE_SPLIT -- requirements
Module: genie_split

Interface
REQ-001 Parameter NO, default 2: number of output ports, >= 1.
REQ-002 Parameter WIDTH, default 1: data width per beat, >= 1.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 i_data  input  WIDTH  input beat data.
REQ-006 i_valid  input  1  input beat valid.
REQ-007 o_ready  output  1  input beat accepted when high together with i_valid.
REQ-008 i_eop  input  1  last beat of the packet.
REQ-009 i_mask  input  NO  destination set; sampled on the first beat of each packet only.
REQ-010 o_data  output  [NO][WIDTH]  every element equals i_data.
REQ-011 o_valid  output  NO  per-output beat valid.
REQ-012 i_ready  input  NO  per-output ready.
REQ-013 o_eop  output  NO  every element equals i_eop.

Function
REQ-014 The block SHALL be a packet-aware 1-to-NO multicast splitter with zero-cycle latency (combinational data and valid path); beat j is sent when o_valid[j] && i_ready[j].
REQ-015 FSM SHALL have two states: S_FIRST (next beat starts a packet) and S_LOCKED (mid-packet).
REQ-016 Active destination set sel SHALL be i_mask in S_FIRST and the registered mask held_mask in S_LOCKED.
REQ-017 done[NO] register: done[j] set on a sent beat at output j while the input beat is not accepted; all bits cleared when the input beat is accepted.
REQ-018 o_valid[j] SHALL equal i_valid && sel[j] && !done[j].
REQ-019 o_ready SHALL equal AND over j of (!sel[j] || done[j] || i_ready[j]); it must not depend on i_valid.
REQ-020 Input beat accepted = i_valid && o_ready; each selected output sees each beat exactly once, with no duplication and no loss.
REQ-021 S_FIRST -> S_LOCKED on an accepted beat with i_eop=0; held_mask loads i_mask on that edge.
REQ-022 S_LOCKED -> S_FIRST on an accepted beat with i_eop=1; a single-beat packet (i_eop=1 on first beat) stays in S_FIRST.
REQ-023 i_mask SHALL be ignored in S_LOCKED; changes mid-packet have no effect.
REQ-024 An all-zero sel SHALL give o_ready=1 and all o_valid=0; the beat is consumed and dropped, with FSM transitions as normal.
REQ-025 Outputs SHALL accept beats independently; a stalled output blocks o_ready but not delivery to the other selected outputs.
REQ-026 When an output's i_ready is asserted in the same cycle as the final missing handshake, the beat SHALL be accepted that cycle and done SHALL clear with no extra bubble.
REQ-027 i_valid is required to stay high, with stable data, until accepted; a deasserted i_valid is ignored by the block and done is left unchanged.

Reset
REQ-028 reset SHALL put the FSM in S_FIRST, clear done to 0 and clear held_mask to 0, taking effect on the next rising edge and overriding all other updates.
REQ-029 Outputs during and after reset SHALL be purely combinational per REQ-018/019; with i_valid=0 all o_valid=0.
REQ-030 Reset asserted mid-packet SHALL abandon the packet; the next accepted beat is treated as a first beat.

Structure
REQ-031 The FSM state enum (S_FIRST, S_LOCKED) SHALL live in the shared package genie_pkg.
REQ-032 The per-beat multicast handshake logic (done register, o_valid, o_ready) SHALL be the sub-module genie_split_fork (parameter NO); genie_split holds the FSM and held_mask.
REQ-033 Implementation SHALL use no storage other than state, held_mask and done.

Verification
REQ-034 NO=4, 3-beat packet, i_mask=0101 on beat 0 then 1111, all i_ready=1 -> beats appear only on outputs 0 and 2, one beat per cycle, o_ready=1 for 3 cycles.
REQ-035 NO=2, mask=11, i_ready=10 for 2 cycles then 11 -> output 1 sends cycle 0; o_valid[1]=0 and o_ready=0 in cycle 1; output 0 sends cycle 2 and o_ready=1 in cycle 2.
REQ-036 Single-beat packet (i_eop=1) with mask=01, then mask=10 packet -> first goes to output 0 only, second to output 1 only; FSM stays in S_FIRST.
REQ-037 i_mask=00, 2-beat packet -> o_ready=1, no o_valid asserted, FSM returns to S_FIRST after beat 2.
REQ-038 Reset in S_LOCKED with done=01 -> next cycle done=00, FSM in S_FIRST, next beat uses the current i_mask.
REQ-039 Random valid/ready/mask stress, NO=3, 1000 packets -> scoreboard shows each output receives exactly its masked packets in order, with eop intact.

Source files
------------

// File: rtl/genie_pkg.sv
// Shared types for the genie packet splitter.
// The FSM state encoding is shared with the bench through the debug port.
package genie_pkg;

    typedef enum logic {
        S_FIRST  = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

endpackage

// File: rtl/genie_split_if.sv
// Input beat stream plus NO fanned-out output streams of the splitter.
// Handshake: a beat moves on a channel in every cycle where its valid and ready are both high.
interface genie_split_if #(
    parameter int NO    = 2,
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0]         i_data;
    logic                     i_valid;
    logic                     o_ready;
    logic                     i_eop;
    logic [NO-1:0]            i_mask;
    logic [NO-1:0][WIDTH-1:0] o_data;
    logic [NO-1:0]            o_valid;
    logic [NO-1:0]            i_ready;
    logic [NO-1:0]            o_eop;

    modport slave (
        input  i_data, i_valid, i_eop, i_mask, i_ready,
        output o_ready, o_data, o_valid, o_eop
    );

    modport master (
        output i_data, i_valid, i_eop, i_mask, i_ready,
        input  o_ready, o_data, o_valid, o_eop
    );
endinterface

// File: rtl/genie_split_fork.sv
// Per-beat multicast handshake: tracks which selected outputs already took the current beat.
// The input beat is released only once every selected output has taken it.
module genie_split_fork #(
    parameter int NO = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_valid,
    input  logic [NO-1:0] i_sel,
    input  logic [NO-1:0] i_ready,
    output logic [NO-1:0] o_valid,
    output logic          o_ready,
    output logic          o_accept,
    output logic [NO-1:0] o_done
);

    logic [NO-1:0] r_done;
    logic [NO-1:0] w_sent;

    assign o_valid  = {NO{i_valid}} & i_sel & ~r_done;
    assign w_sent   = o_valid & i_ready;
    // Ready is independent of i_valid so upstream may wait on it combinationally.
    assign o_ready  = &(~i_sel | r_done | i_ready);
    assign o_accept = i_valid & o_ready;
    assign o_done   = r_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_done <= '0;
        end else if (o_accept) begin
            r_done <= '0;
        end else if (i_valid) begin
            r_done <= r_done | w_sent;
        end
    end

endmodule

// File: rtl/genie_split.sv
// Packet-aware 1-to-NO multicast splitter with zero-cycle latency.
// The destination set is taken from i_mask on the first beat and held for the rest of the packet.
module genie_split
    import genie_pkg::*;
#(
    parameter int NO    = 2,
    parameter int WIDTH = 1
) (
    input  logic            clk,
    input  logic            reset,
    genie_split_if.slave    bus,
    output state_t          o_dbg_state,
    output logic [NO-1:0]   o_dbg_done
);

    state_t        r_state;
    logic [NO-1:0] r_held_mask;
    logic [NO-1:0] w_sel;
    logic          w_accept;
    logic          w_ready;
    logic [NO-1:0] w_valid;
    logic [NO-1:0] w_done;

    assign w_sel = (r_state == S_FIRST) ? bus.i_mask : r_held_mask;

    genie_split_fork #(
        .NO (NO)
    ) u_fork (
        .clk      (clk),
        .reset    (reset),
        .i_valid  (bus.i_valid),
        .i_sel    (w_sel),
        .i_ready  (bus.i_ready),
        .o_valid  (w_valid),
        .o_ready  (w_ready),
        .o_accept (w_accept),
        .o_done   (w_done)
    );

    assign bus.o_valid = w_valid;
    assign bus.o_ready = w_ready;
    assign bus.o_eop   = {NO{bus.i_eop}};

    for (genvar j = 0; j < NO; j++) begin : g_data
        assign bus.o_data[j] = bus.i_data;
    end

    // Packet framing; an empty mask still walks the FSM so the packet is dropped whole.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_FIRST;
            r_held_mask <= '0;
        end else if (w_accept) begin
            case (r_state)
                S_FIRST: begin
                    if (!bus.i_eop) begin
                        r_state     <= S_LOCKED;
                        r_held_mask <= bus.i_mask;
                    end
                end
                S_LOCKED: begin
                    if (bus.i_eop) begin
                        r_state <= S_FIRST;
                    end
                end
                default: r_state <= S_FIRST;
            endcase
        end
    end

    assign o_dbg_state = r_state;
    assign o_dbg_done  = w_done;

endmodule

// File: tb/tb_genie_split.sv
// Directed checks on NO=4 and NO=2 splitters plus a scoreboarded random stream on NO=3.
module tb_genie_split;
    import genie_pkg::*;

    localparam int W = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    genie_split_if #(.NO(4), .WIDTH(W)) if4 ();
    genie_split_if #(.NO(2), .WIDTH(W)) if2 ();
    genie_split_if #(.NO(3), .WIDTH(W)) if3 ();

    state_t     st4, st2, st3;
    logic [3:0] done4;
    logic [1:0] done2;
    logic [2:0] done3;

    genie_split #(.NO(4), .WIDTH(W)) dut4 (
        .clk (clk), .reset (reset), .bus (if4.slave), .o_dbg_state (st4), .o_dbg_done (done4)
    );
    genie_split #(.NO(2), .WIDTH(W)) dut2 (
        .clk (clk), .reset (reset), .bus (if2.slave), .o_dbg_state (st2), .o_dbg_done (done2)
    );
    genie_split #(.NO(3), .WIDTH(W)) dut3 (
        .clk (clk), .reset (reset), .bus (if3.slave), .o_dbg_state (st3), .o_dbg_done (done3)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard for the NO=3 stream: {eop, data} per output, in order.
    logic [W:0] exp_q [3][$];

    always @(negedge clk) begin
        for (int j = 0; j < 3; j++) begin
            if (if3.o_valid[j] && if3.i_ready[j]) begin
                check_val("sb_expected_beat", 64'(exp_q[j].size() != 0), 64'd1);
                if (exp_q[j].size() != 0)
                    check_val("sb_beat", 64'({if3.o_eop[j], if3.o_data[j]}), 64'(exp_q[j].pop_front()));
            end
        end
    end

    logic       acc;
    int         cyc;
    logic [2:0] pmask;
    int         plen;
    logic [W-1:0] d;
    logic       e;

    initial begin
        reset = 1'b1;
        if4.i_data = '0; if4.i_valid = 0; if4.i_eop = 0; if4.i_mask = '0; if4.i_ready = '0;
        if2.i_data = '0; if2.i_valid = 0; if2.i_eop = 0; if2.i_mask = '0; if2.i_ready = '0;
        if3.i_data = '0; if3.i_valid = 0; if3.i_eop = 0; if3.i_mask = '0; if3.i_ready = '0;
        step();
        step();
        @(negedge clk);
        check_val("rst_state4", 64'(st4), 64'(S_FIRST));
        check_val("rst_done4", 64'(done4), 64'd0);
        check_val("rst_valid4", 64'(if4.o_valid), 64'd0);
        check_val("rst_ready4", 64'(if4.o_ready), 64'd1);
        check_val("rst_state2", 64'(st2), 64'(S_FIRST));
        check_val("rst_done2", 64'(done2), 64'd0);
        step();
        reset = 1'b0;

        // NO=4, 3-beat packet to outputs 0 and 2; later mask changes are ignored
        if4.i_valid = 1; if4.i_ready = 4'b1111;
        if4.i_data = 8'hA1; if4.i_eop = 0; if4.i_mask = 4'b0101;
        @(negedge clk);
        check_val("p4_b0_valid", 64'(if4.o_valid), 64'b0101);
        check_val("p4_b0_ready", 64'(if4.o_ready), 64'd1);
        check_val("p4_b0_data0", 64'(if4.o_data[0]), 64'hA1);
        check_val("p4_b0_data2", 64'(if4.o_data[2]), 64'hA1);
        check_val("p4_b0_eop", 64'(if4.o_eop), 64'd0);
        step();
        check_val("p4_locked", 64'(st4), 64'(S_LOCKED));
        if4.i_data = 8'hA2; if4.i_mask = 4'b1111;
        @(negedge clk);
        check_val("p4_b1_valid", 64'(if4.o_valid), 64'b0101);
        check_val("p4_b1_ready", 64'(if4.o_ready), 64'd1);
        step();
        if4.i_data = 8'hA3; if4.i_eop = 1;
        @(negedge clk);
        check_val("p4_b2_valid", 64'(if4.o_valid), 64'b0101);
        check_val("p4_b2_eop", 64'(if4.o_eop), 64'b1111);
        check_val("p4_b2_ready", 64'(if4.o_ready), 64'd1);
        check_val("p4_b2_data2", 64'(if4.o_data[2]), 64'hA3);
        step();
        if4.i_valid = 0;
        @(negedge clk);
        check_val("p4_end_state", 64'(st4), 64'(S_FIRST));
        check_val("p4_idle_valid", 64'(if4.o_valid), 64'd0);
        step();

        // NO=2, output 0 stalls for two cycles
        if2.i_valid = 1; if2.i_data = 8'h5A; if2.i_eop = 1; if2.i_mask = 2'b11; if2.i_ready = 2'b10;
        @(negedge clk);
        check_val("stall_c0_valid", 64'(if2.o_valid), 64'b11);
        check_val("stall_c0_ready", 64'(if2.o_ready), 64'd0);
        step();
        @(negedge clk);
        check_val("stall_c1_done", 64'(done2), 64'b10);
        check_val("stall_c1_valid", 64'(if2.o_valid), 64'b01);
        check_val("stall_c1_ready", 64'(if2.o_ready), 64'd0);
        step();
        if2.i_ready = 2'b11;
        @(negedge clk);
        check_val("stall_c2_valid", 64'(if2.o_valid), 64'b01);
        check_val("stall_c2_ready", 64'(if2.o_ready), 64'd1);
        step();
        if2.i_valid = 0;
        @(negedge clk);
        check_val("stall_done_clr", 64'(done2), 64'd0);
        check_val("stall_state", 64'(st2), 64'(S_FIRST));

        // Two single-beat packets with different masks
        if2.i_valid = 1; if2.i_data = 8'h11; if2.i_eop = 1; if2.i_mask = 2'b01; if2.i_ready = 2'b11;
        @(negedge clk);
        check_val("sb1_valid", 64'(if2.o_valid), 64'b01);
        check_val("sb1_ready", 64'(if2.o_ready), 64'd1);
        step();
        check_val("sb1_state", 64'(st2), 64'(S_FIRST));
        if2.i_data = 8'h22; if2.i_mask = 2'b10;
        @(negedge clk);
        check_val("sb2_valid", 64'(if2.o_valid), 64'b10);
        check_val("sb2_data1", 64'(if2.o_data[1]), 64'h22);
        step();
        check_val("sb2_state", 64'(st2), 64'(S_FIRST));

        // Empty mask: beats are consumed and dropped, framing still tracked
        if2.i_data = 8'h40; if2.i_eop = 0; if2.i_mask = 2'b00; if2.i_ready = 2'b00;
        @(negedge clk);
        check_val("drop_b0_valid", 64'(if2.o_valid), 64'd0);
        check_val("drop_b0_ready", 64'(if2.o_ready), 64'd1);
        step();
        check_val("drop_locked", 64'(st2), 64'(S_LOCKED));
        if2.i_data = 8'h41; if2.i_eop = 1; if2.i_mask = 2'b11;
        @(negedge clk);
        check_val("drop_b1_valid", 64'(if2.o_valid), 64'd0);
        check_val("drop_b1_ready", 64'(if2.o_ready), 64'd1);
        step();
        check_val("drop_end_state", 64'(st2), 64'(S_FIRST));

        // Reset mid-packet with one output already served
        if2.i_data = 8'h31; if2.i_eop = 0; if2.i_mask = 2'b11; if2.i_ready = 2'b11;
        step();
        check_val("rl_locked", 64'(st2), 64'(S_LOCKED));
        if2.i_data = 8'h32; if2.i_mask = 2'b00; if2.i_ready = 2'b01;
        @(negedge clk);
        check_val("rl_b1_valid", 64'(if2.o_valid), 64'b11);
        check_val("rl_b1_ready", 64'(if2.o_ready), 64'd0);
        step();
        check_val("rl_done", 64'(done2), 64'b01);
        if2.i_valid = 0;
        step();
        check_val("rl_done_hold", 64'(done2), 64'b01);
        check_val("rl_idle_valid", 64'(if2.o_valid), 64'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_val("rl_rst_done", 64'(done2), 64'd0);
        check_val("rl_rst_state", 64'(st2), 64'(S_FIRST));
        if2.i_valid = 1; if2.i_data = 8'h33; if2.i_eop = 1; if2.i_mask = 2'b10; if2.i_ready = 2'b11;
        @(negedge clk);
        check_val("rl_new_valid", 64'(if2.o_valid), 64'b10);
        check_val("rl_new_ready", 64'(if2.o_ready), 64'd1);
        step();
        if2.i_valid = 0;
        check_val("rl_new_state", 64'(st2), 64'(S_FIRST));

        // Random stream on NO=3
        for (int p = 0; p < 1000; p++) begin
            pmask = 3'($urandom_range(0, 7));
            plen  = $urandom_range(1, 4);
            for (int b = 0; b < plen; b++) begin
                d = W'($urandom_range(0, 255));
                e = (b == plen - 1);
                if3.i_data  = d;
                if3.i_eop   = e;
                if3.i_mask  = (b == 0) ? pmask : 3'($urandom_range(0, 7));
                if3.i_valid = 1;
                for (int j = 0; j < 3; j++)
                    if (pmask[j]) exp_q[j].push_back({e, d});
                acc = 0;
                cyc = 0;
                while (!acc && cyc < 64) begin
                    if3.i_ready = 3'($urandom_range(0, 7));
                    @(negedge clk);
                    acc = if3.o_ready;
                    step();
                    cyc++;
                end
                check_val("stress_accept", 64'(acc), 64'd1);
                if3.i_valid = 0;
                if ($urandom_range(0, 3) == 0) step();
            end
        end
        step();
        for (int j = 0; j < 3; j++)
            check_val("sb_drain", 64'(exp_q[j].size()), 64'd0);
        check_val("stress_end_state", 64'(st3), 64'(S_FIRST));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
